// File: rtl/sercmd_pkg.sv
// Shared opcode/response constants and FSM state encoding for the serial command decoder.
package sercmd_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_CHK = 8'h21;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_GET_CHK  = 3'd3,
        ST_REG_WR   = 3'd4,
        ST_REG_RD   = 3'd5,
        ST_RD_WAIT  = 3'd6,
        ST_SEND     = 3'd7
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WR) || (b == OP_RD);
    endfunction

endpackage

// File: rtl/sercmd_timeout.sv
// Inter-byte watchdog: reloads on clr_i, counts down while en_i, flags expiry at zero.
import sercmd_pkg::*;

module sercmd_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on a popped byte, otherwise decrement toward zero while armed.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/serial_cmd_decoder.sv
// Parses 'W' addr data / 'R' addr frames from the RX FIFO, drives the register bus, returns one byte.
// Optional trailing XOR checksum byte when SERCMD_CHKSUM_EN is defined.
import sercmd_pkg::*;

module serial_cmd_decoder #(
    parameter int ADDR_W      = 8,
    parameter int RD_LATENCY  = 1,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmdfifo_rxe,
    input  logic [7:0]        cmdfifo_drx,
    output logic              cmdfifo_rd,
    input  logic              cmdfifo_txf,
    output logic [7:0]        cmdfifo_dtx,
    output logic              cmdfifo_wr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy_o,
    output logic              cmd_err_o
);

    state_e            state_q, state_d;
    logic              gap_q, gap_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rsp_q, rsp_d;
    logic              we_q, we_d, re_q, re_d, err_q, err_d, busy_q, busy_d;
    logic [2:0]        lat_q, lat_d;
`ifdef SERCMD_CHKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif
    logic in_get_s, pop_s, expire_s;

    assign in_get_s = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA) || (state_q == ST_GET_CHK);
    // The cycle after a pop is skipped so the FIFO empty flag can settle.
    assign pop_s      = !reset_i && (in_get_s || (state_q == ST_IDLE)) && !gap_q && !cmdfifo_rxe;
    assign cmdfifo_rd = pop_s;
    assign cmdfifo_wr = !reset_i && (state_q == ST_SEND) && !cmdfifo_txf;

    sercmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (pop_s),
        .en_i     (in_get_s),
        .expire_o (expire_s)
    );

    // Frame-parsing FSM next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        gap_d   = pop_s;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        lat_d   = lat_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        err_d   = 1'b0;
`ifdef SERCMD_CHKSUM_EN
        if (pop_s) begin
            chk_d = (state_q == ST_IDLE) ? cmdfifo_drx : (chk_q ^ cmdfifo_drx);
        end else begin
            chk_d = chk_q;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop_s && is_opcode(cmdfifo_drx)) begin
                    is_wr_d = (cmdfifo_drx == OP_WR);
                    state_d = ST_GET_ADDR;
                end else if (pop_s) begin
                    rsp_d   = RSP_BAD;
                    err_d   = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_ADDR: begin
                if (pop_s) begin
                    addr_d = cmdfifo_drx[ADDR_W-1:0];
                    if (is_wr_q) begin
                        state_d = ST_GET_DATA;
                    end else begin
`ifdef SERCMD_CHKSUM_EN
                        state_d = ST_GET_CHK;
`else
                        re_d    = 1'b1;
                        state_d = ST_REG_RD;
`endif
                    end
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GET_ADDR;
                end
            end
            ST_GET_DATA: begin
                if (pop_s) begin
                    wdata_d = cmdfifo_drx;
`ifdef SERCMD_CHKSUM_EN
                    state_d = ST_GET_CHK;
`else
                    we_d    = 1'b1;
                    state_d = ST_REG_WR;
`endif
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GET_DATA;
                end
            end
            ST_GET_CHK: begin
`ifdef SERCMD_CHKSUM_EN
                if (pop_s && (cmdfifo_drx == chk_q)) begin
                    we_d    = is_wr_q;
                    re_d    = !is_wr_q;
                    state_d = is_wr_q ? ST_REG_WR : ST_REG_RD;
                end else if (pop_s) begin
                    rsp_d   = RSP_CHK;
                    err_d   = 1'b1;
                    state_d = ST_SEND;
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GET_CHK;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_REG_WR: begin
                rsp_d   = RSP_ACK;
                state_d = ST_SEND;
            end
            ST_REG_RD: begin
                lat_d   = 3'd1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (lat_q == 3'(RD_LATENCY)) begin
                    rsp_d   = reg_rdata;
                    state_d = ST_SEND;
                end else begin
                    lat_d   = lat_q + 3'd1;
                end
            end
            ST_SEND: begin
                if (!cmdfifo_txf) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            gap_q   <= 1'b0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            rsp_q   <= 8'h00;
            lat_q   <= 3'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERCMD_CHKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            lat_q   <= lat_d;
            we_q    <= we_d;
            re_q    <= re_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef SERCMD_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign cmdfifo_dtx = rsp_q;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_we      = we_q;
    assign reg_re      = re_q;
    assign busy_o      = busy_q;
    assign cmd_err_o   = err_q;

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Self-checking bench: table vectors, hand-written corner sequences, randomized frames vs a frame-level model.
module tb_serial_cmd_decoder;

    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int TMO    = 50;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       cmdfifo_rxe = 1'b1;
    logic [7:0] cmdfifo_drx = 8'h00;
    logic       cmdfifo_rd;
    logic       cmdfifo_txf = 1'b0;
    logic [7:0] cmdfifo_dtx;
    logic       cmdfifo_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re;
    logic [7:0] reg_rdata = 8'hEE;
    logic       busy_o, cmd_err_o;

    always #5 clk = ~clk;

    serial_cmd_decoder #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .cmdfifo_rxe(cmdfifo_rxe), .cmdfifo_drx(cmdfifo_drx), .cmdfifo_rd(cmdfifo_rd),
        .cmdfifo_txf(cmdfifo_txf), .cmdfifo_dtx(cmdfifo_dtx), .cmdfifo_wr(cmdfifo_wr),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy_o(busy_o), .cmd_err_o(cmd_err_o)
    );

    logic [7:0]  rxq[$];
    logic [7:0]  exp_rsp[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  periph_mem[256];
    logic [7:0]  model_mem[256];
    int n_pass = 0, n_total = 0;
    int exp_err = 0, obs_err = 0, cyc = 0, pop_cyc = 0, err_cyc = 0, wr_cnt = 0;
    int txf_mode = 2;
    bit prev_wr = 1'b0, prev_rd = 1'b0, rd_pend = 1'b0;
    int rd_cnt = 0;
    logic [7:0] rd_val = 8'h00;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [7:0] rsp;
        bit we, re, err;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // FIFO / register-file environment: drive inputs at negedge, then observe the cycle's outputs.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            cmdfifo_rxe = (rxq.size() == 0);
            cmdfifo_drx = cmdfifo_rxe ? 8'h00 : rxq[0];
            if (txf_mode == 0) cmdfifo_txf = ($urandom_range(0, 3) == 0);
            else cmdfifo_txf = (txf_mode == 1);
            reg_rdata = 8'hEE;
            if (rd_pend) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    reg_rdata = rd_val;
                    rd_pend = 1'b0;
                end
            end
            #1;
            if (reset_i) begin
                prev_wr = 1'b0; prev_rd = 1'b0; rd_pend = 1'b0;
            end else begin
                if (cmdfifo_rd) begin
                    chk("rd_when_empty", cmdfifo_rxe, 0);
                    chk("rd_gap", prev_rd, 0);
                    if (!cmdfifo_rxe) void'(rxq.pop_front());
                    pop_cyc = cyc;
                end
                if (cmdfifo_wr) begin
                    chk("wr_while_full", cmdfifo_txf, 0);
                    chk("wr_back_to_back", prev_wr, 0);
                    chk("rsp_expected", exp_rsp.size() > 0, 1);
                    if (exp_rsp.size() > 0) chk("rsp_byte", cmdfifo_dtx, exp_rsp.pop_front());
                    wr_cnt++;
                end
                if (reg_we) begin
                    chk("we_expected", exp_wr.size() > 0, 1);
                    if (exp_wr.size() > 0) chk("we_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
                    periph_mem[reg_addr] = reg_wdata;
                end
                if (reg_re) begin
                    chk("re_expected", exp_rd.size() > 0, 1);
                    if (exp_rd.size() > 0) chk("re_addr", reg_addr, exp_rd.pop_front());
                    rd_pend = 1'b1; rd_cnt = RD_LAT; rd_val = periph_mem[reg_addr];
                end
                if (cmd_err_o) begin
                    obs_err++;
                    err_cyc = cyc;
                end
                prev_wr = cmdfifo_wr;
                prev_rd = cmdfifo_rd;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk);
        rxq.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, input int max_gap);
        logic [7:0] fb[3];
        int n;
`ifdef SERCMD_CHKSUM_EN
        logic [7:0] x;
`endif
        fb[0] = b0; fb[1] = b1; fb[2] = b2;
        n = (b0 == 8'h57) ? 3 : ((b0 == 8'h52) ? 2 : 1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            push_byte(fb[i]);
        end
`ifdef SERCMD_CHKSUM_EN
        if (n > 1) begin
            x = 8'h00;
            for (int i = 0; i < n; i++) x = x ^ fb[i];
            push_byte(x);
        end
`endif
    endtask

    // Frame-level reference: what a frame must do to the register file and which byte comes back.
    task automatic expect_model(input logic [7:0] b0, b1, b2);
        if (b0 == 8'h57) begin
            exp_wr.push_back({b1, b2});
            model_mem[b1] = b2;
            exp_rsp.push_back(8'h4B);
        end else if (b0 == 8'h52) begin
            exp_rd.push_back(b1);
            exp_rsp.push_back(model_mem[b1]);
        end else begin
            exp_rsp.push_back(8'h3F);
            exp_err++;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while ((rxq.size() != 0 || busy_o || exp_rsp.size() != 0 || exp_wr.size() != 0 ||
                exp_rd.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_done_in_budget"}, k < budget, 1);
        repeat (3) @(negedge clk);
        chk({name, "_err_count"}, obs_err, exp_err);
        exp_rsp.delete(); exp_wr.delete(); exp_rd.delete();
        exp_err = obs_err;
    endtask

    initial begin
        logic [7:0] a, d, op;
        int e0, k, wc;
        for (int i = 0; i < 256; i++) begin
            periph_mem[i] = 8'(i) ^ 8'h5A;
            model_mem[i]  = 8'(i) ^ 8'h5A;
        end
        tbl[0] = '{8'h57, 8'h05, 8'hA3, 8'h4B, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h57, 8'h10, 8'h3C, 8'h4B, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h52, 8'h10, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h52, 8'h05, 8'h00, 8'hA3, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h41, 8'h00, 8'h00, 8'h3F, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h3F, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{8'h52, 8'h77, 8'h00, 8'h2D, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'hFF, 8'h00, 8'h00, 8'h3F, 1'b0, 1'b0, 1'b1};

        // Reset state, with a byte already waiting that must not be popped during reset.
        rxq.push_back(8'h41);
        repeat (4) @(negedge clk);
        #2;
        chk("reset_outputs", {cmdfifo_rd, cmdfifo_wr, cmdfifo_dtx, reg_addr, reg_wdata,
                              reg_we, reg_re, busy_o, cmd_err_o}, 0);
        chk("reset_no_pop", rxq.size(), 1);
        exp_rsp.push_back(8'h3F);
        exp_err++;
        @(negedge clk);
        reset_i = 1'b0;
        wait_idle("post_reset", 100);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].we) begin
                exp_wr.push_back({tbl[i].b1, tbl[i].b2});
                model_mem[tbl[i].b1] = tbl[i].b2;
            end
            if (tbl[i].re) exp_rd.push_back(tbl[i].b1);
            if (tbl[i].err) exp_err++;
            exp_rsp.push_back(tbl[i].rsp);
            send_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2, 2);
            wait_idle($sformatf("tbl%0d", i), 200);
        end

        // Stall after the opcode: abort after TMO cycles without response, then a read still works.
        e0 = obs_err;
        push_byte(8'h57);
        k = 0;
        while (obs_err == e0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_err_seen", obs_err, e0 + 1);
        chk("tmo_latency", err_cyc - pop_cyc, 51);
        chk("tmo_back_idle", busy_o, 0);
        exp_err++;
        wait_idle("tmo", 100);
        expect_model(8'h52, 8'h01, 8'h00);
        send_frame(8'h52, 8'h01, 8'h00, 0);
        wait_idle("tmo_then_read", 200);

        // Backpressure: TX full holds the response; exactly one push after release.
        txf_mode = 1;
        expect_model(8'h57, 8'h20, 8'h11);
        send_frame(8'h57, 8'h20, 8'h11, 0);
        wc = wr_cnt;
        repeat (30) @(negedge clk);
        chk("bp_no_wr", wr_cnt, wc);
        chk("bp_busy", busy_o, 1);
        txf_mode = 2;
        wait_idle("bp", 100);
        chk("bp_one_wr", wr_cnt, wc + 1);

        // Reset in the middle of a frame discards it.
        push_byte(8'h57);
        push_byte(8'h05);
        k = 0;
        while (rxq.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("midrst_outputs", {cmdfifo_rd, cmdfifo_wr, cmdfifo_dtx, reg_addr, reg_wdata,
                               reg_we, reg_re, busy_o, cmd_err_o}, 0);
        @(negedge clk);
        reset_i = 1'b0;
        expect_model(8'h57, 8'h06, 8'h44);
        send_frame(8'h57, 8'h06, 8'h44, 1);
        expect_model(8'h52, 8'h06, 8'h00);
        send_frame(8'h52, 8'h06, 8'h00, 1);
        wait_idle("midrst_recover", 300);

`ifdef SERCMD_CHKSUM_EN
        exp_wr.push_back({8'h05, 8'hA3});
        model_mem[8'h05] = 8'hA3;
        exp_rsp.push_back(8'h4B);
        push_byte(8'h57); push_byte(8'h05); push_byte(8'hA3); push_byte(8'hF1);
        wait_idle("chk_good", 200);
        exp_rsp.push_back(8'h21);
        exp_err++;
        push_byte(8'h57); push_byte(8'h05); push_byte(8'hA3); push_byte(8'h00);
        wait_idle("chk_bad_wr", 200);
        exp_rsp.push_back(8'h21);
        exp_err++;
        push_byte(8'h52); push_byte(8'h05); push_byte(8'h00);
        wait_idle("chk_bad_rd", 200);
`endif

        // Randomized back-to-back frames with random TX backpressure.
        txf_mode = 0;
        for (int f = 0; f < 80; f++) begin
            k = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            if (k < 4) op = 8'h57;
            else if (k < 8) op = 8'h52;
            else begin
                op = 8'($urandom_range(0, 255));
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
            end
            expect_model(op, a, d);
            send_frame(op, a, d, 4);
            if ((f % 10) == 9) wait_idle($sformatf("rand%0d", f), 2000);
        end
        txf_mode = 2;
        wait_idle("rand_end", 2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
